// File: rtl/soc_debug_pkg.sv
// Shared definitions for the LED reporter: TX state encodings, ASCII constants, drop-counter limit.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package soc_debug_pkg;

    // Bit-level states of the UART byte shifter
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    // Word-level states of the byte sequencer; LOAD holds a freshly popped word and offers byte 0
    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_LOAD,
        SEQ_SEND
    } seq_state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_A    = 8'h41;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] DROP_MAX   = 8'd255;

    // Uppercase ASCII hex digit for one nibble
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            hex_ascii = ASCII_ZERO + {4'h0, nib};
        end else begin
            hex_ascii = ASCII_A + {4'h0, nib} - 8'd10;
        end
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte transmitter, LSB first, CLKS_PER_BIT cycles per bit.
// Latency: byte accepted on an edge drives the start bit from that edge on; a frame is 10 bit times.
// Backpressure: tx_ready is high when idle and in the final stop-bit cycle, so frames can abut with no gap.
module uart_tx_byte
    import soc_debug_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    output logic       txd
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

    tx_state_t     state;
    tx_state_t     state_next;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          bit_end;
    logic          accept;

    assign bit_end = (timer == T_LAST);
    assign accept  = tx_valid && tx_ready;

    // State register; reset abandons any frame in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= TX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, line level and ready; txd is decoded from state so reset forces the line high at once
    always_comb begin
        state_next = state;
        tx_ready   = 1'b0;
        txd        = 1'b1;
        case (state)
            TX_IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    state_next = TX_START;
                end
            end
            TX_START: begin
                txd = 1'b0;
                if (bit_end) begin
                    state_next = TX_DATA;
                end
            end
            TX_DATA: begin
                txd = shreg[0];
                if (bit_end && (bit_idx == 3'd7)) begin
                    state_next = TX_STOP;
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    tx_ready   = 1'b1;
                    state_next = tx_valid ? TX_START : TX_IDLE;
                end
            end
            default: state_next = TX_IDLE;
        endcase
    end

    // Bit timer, bit index and shift register; timer and index wrap to 0 at their terminal values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if ((state == TX_IDLE) || bit_end) begin
                timer <= '0;
            end else begin
                timer <= timer + TW'(1);
            end
            if ((state == TX_DATA) && bit_end) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (accept) begin
                shreg <= tx_data;
            end else if ((state == TX_DATA) && bit_end) begin
                shreg <= {1'b0, shreg[7:1]};
            end
        end
    end

endmodule

// File: rtl/leds_uart_reporter.sv
// Snapshots every change of LEDS into a FIFO and streams each snapshot out of TXD (raw MSB-byte first, or ASCII hex + LF with LEDS_REPORT_HEX_EN).
// Latency: change seen at edge N is written at N, popped at N+1, start bit from N+2.
// Backpressure: none upstream; a change arriving while the FIFO is full is dropped and counted (saturating).
module leds_uart_reporter
    import soc_debug_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int WIDTH        = 32
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [WIDTH-1:0]            LEDS,
    output logic                        TXD,
    output logic                        busy,
    output logic [7:0]                  dropped,
    output logic [$clog2(FIFO_DEPTH):0] level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
`ifdef LEDS_REPORT_HEX_EN
    localparam int NB = WIDTH / 4 + 1;
`else
    localparam int NB = WIDTH / 8;
`endif
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BW-1:0] LAST_BYTE = BW'(NB - 1);

    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] word;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic [7:0]       drop_cnt;
    logic             push;
    logic             push_ok;
    logic             pop;
    logic             full;
    logic             empty;

    seq_state_t       seq_state;
    seq_state_t       seq_next;
    logic [BW-1:0]    byte_idx;
    logic [BW-1:0]    sel_idx;
    logic             tx_valid;
    logic             tx_ready;
    logic [7:0]       tx_data;

    assign push    = (LEDS != prev);
    assign full    = (count == LW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push
    assign push_ok = push && (!full || pop);
    assign head    = mem[rd_ptr];

    assign level   = count;
    assign dropped = drop_cnt;
    assign busy    = !empty || (seq_state != SEQ_IDLE);

    // Change detector: prev always follows LEDS so each change is seen exactly once
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            prev <= '0;
        end else begin
            prev <= LEDS;
        end
    end

    // Snapshot storage; contents need no reset because occupancy is tracked separately
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr] <= LEDS;
        end
    end

    // FIFO pointers, occupancy and saturating drop counter
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
            if (push && !push_ok && (drop_cnt != DROP_MAX)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    // Sequencer state register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            seq_state <= SEQ_IDLE;
        end else begin
            seq_state <= seq_next;
        end
    end

    // Sequencer: pop a word, then offer each byte so the shifter can chain frames without idle time
    always_comb begin
        seq_next = seq_state;
        pop      = 1'b0;
        tx_valid = 1'b0;
        sel_idx  = byte_idx;
        case (seq_state)
            SEQ_IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    seq_next = SEQ_LOAD;
                end
            end
            SEQ_LOAD: begin
                tx_valid = 1'b1;
                sel_idx  = '0;
                if (tx_ready) begin
                    seq_next = SEQ_SEND;
                end
            end
            SEQ_SEND: begin
                // In SEND, tx_ready only rises in the last stop-bit cycle of the current byte
                if (tx_ready) begin
                    if (byte_idx != LAST_BYTE) begin
                        tx_valid = 1'b1;
                        sel_idx  = byte_idx + BW'(1);
                    end else if (!empty) begin
                        pop      = 1'b1;
                        seq_next = SEQ_LOAD;
                    end else begin
                        seq_next = SEQ_IDLE;
                    end
                end
            end
            default: seq_next = SEQ_IDLE;
        endcase
    end

    // Word holding register and index of the byte currently on the line
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            word     <= '0;
            byte_idx <= '0;
        end else begin
            if (pop) begin
                word <= head;
            end
            if (tx_valid && tx_ready) begin
                byte_idx <= sel_idx;
            end
        end
    end

    // Byte encoder: selected byte of the held word, most significant first
    always_comb begin
`ifdef LEDS_REPORT_HEX_EN
        tx_data = ASCII_LF;
        for (int k = 0; k < NB - 1; k++) begin
            if (sel_idx == BW'(k)) begin
                tx_data = hex_ascii(word[WIDTH-1-4*k -: 4]);
            end
        end
`else
        tx_data = 8'h00;
        for (int k = 0; k < NB; k++) begin
            if (sel_idx == BW'(k)) begin
                tx_data = word[WIDTH-1-8*k -: 8];
            end
        end
`endif
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .clk      (CLK),
        .rst_n    (RESET),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .txd      (TXD)
    );

endmodule

// File: tb/tb_leds_uart_reporter.sv
// Directed bench for leds_uart_reporter: reset, single word, overflow, mid-frame reset, drop saturation.
// Raw mode by default; LEDS_REPORT_HEX_EN switches the single-word test to the ASCII hex frame.
// UART frames are decoded by sampling TXD at mid-bit on the falling clock edge.
module tb_leds_uart_reporter;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int W     = 32;
`ifdef LEDS_REPORT_HEX_EN
    localparam int NB = 9;
`else
    localparam int NB = 4;
`endif
    localparam int WORD_CYC = NB * 10 * CPB;

    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic [W-1:0]  LEDS = '0;
    logic          TXD;
    logic          busy;
    logic [7:0]    dropped;
    logic [2:0]    level;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int last_start = 0;

    leds_uart_reporter #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .WIDTH        (W)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .LEDS    (LEDS),
        .TXD     (TXD),
        .busy    (busy),
        .dropped (dropped),
        .level   (level)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Expected byte k of a word on the wire
    function automatic logic [7:0] exp_byte(input logic [31:0] w, input int k);
        logic [31:0] s;
`ifdef LEDS_REPORT_HEX_EN
        logic [3:0] nib;
        if (k == 8) return 8'h0A;
        s   = w >> (28 - 4 * k);
        nib = s[3:0];
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
`else
        s = w >> (24 - 8 * k);
        return s[7:0];
`endif
    endfunction

    task automatic wait_fall(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge CLK);
            if (TXD === 1'b0) begin
                ok = 1'b1;
                last_start = cyc;
                break;
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic rx_byte(input string name, input logic [7:0] exp);
        bit ok;
        logic [7:0] d;
        wait_fall(ok);
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL %s start: got timeout, expected byte %02h", name, exp);
        end else begin
            repeat (2) @(negedge CLK);
            vectors++;
            if (TXD !== 1'b0) begin
                errors++;
                $display("FAIL %s start bit: got %b, expected 0", name, TXD);
            end
            for (int b = 0; b < 8; b++) begin
                repeat (CPB) @(negedge CLK);
                d[b] = TXD;
            end
            repeat (CPB) @(negedge CLK);
            vectors++;
            if (TXD !== 1'b1) begin
                errors++;
                $display("FAIL %s stop bit: got %b, expected 1", name, TXD);
            end
            vectors++;
            if (d !== exp) begin
                errors++;
                $display("FAIL %s data: got %02h, expected %02h", name, d, exp);
            end
        end
    endtask

    task automatic rx_word(input string name, input logic [31:0] w, output int start);
        start = 0;
        for (int k = 0; k < NB; k++) begin
            rx_byte(name, exp_byte(w, k));
            if (k == 0) start = last_start;
        end
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        LEDS  = 32'hFFFF_FFFF;
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            vectors++;
            if ({TXD, busy, dropped, level} !== {1'b1, 1'b0, 8'd0, 3'd0}) begin
                errors++;
                $display("FAIL reset hold: got txd=%b busy=%b dropped=%0d level=%0d, expected 1 0 0 0",
                         TXD, busy, dropped, level);
            end
        end
        LEDS = '0;
        @(negedge CLK);
        RESET = 1'b1;
        repeat (5) @(negedge CLK);
        vectors++;
        if ({TXD, busy, level} !== {1'b1, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL reset release: got txd=%b busy=%b level=%0d, expected 1 0 0", TXD, busy, level);
        end
    endtask

    // Drive one word and check bytes, first-start latency, word duration and return to idle
    task automatic send_one(input string name, input logic [31:0] w, input logic [7:0] bytes [NB]);
        int c0;
        int t0;
        bit ok;
        @(negedge CLK);
        c0   = cyc;
        LEDS = w;
        t0   = 0;
        for (int k = 0; k < NB; k++) begin
            rx_byte(name, bytes[k]);
            if (k == 0) t0 = last_start;
        end
        vectors++;
        if (t0 - c0 !== 3) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles, expected 3", name, t0 - c0);
        end
        wait_idle(ok);
        vectors++;
        if (!ok || (cyc - t0 !== WORD_CYC)) begin
            errors++;
            $display("FAIL %s duration: got %0d cycles (idle=%b), expected %0d", name, cyc - t0, ok, WORD_CYC);
        end
        vectors++;
        if ({level, dropped} !== {3'd0, 8'd0}) begin
            errors++;
            $display("FAIL %s after: got level=%0d dropped=%0d, expected 0 0", name, level, dropped);
        end
    endtask

`ifdef LEDS_REPORT_HEX_EN
    task automatic test_hex();
        logic [7:0] b [NB];
        b = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0A};
        send_one("hex_word", 32'h1234_ABCD, b);
    endtask
`else
    task automatic test_raw_word();
        logic [7:0] b [NB];
        b = '{8'h00, 8'h00, 8'h00, 8'hA5};
        send_one("raw_word", 32'h0000_00A5, b);
    endtask
`endif

    task automatic test_back_to_back();
        logic [31:0] v [6];
        bit ok;
        v = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
              32'h4444_4444, 32'h5555_5555, 32'h6666_6666};
        fork
            begin
                int s;
                for (int i = 0; i < 5; i++) begin
                    rx_word("b2b_word", v[i], s);
                end
            end
            begin
                for (int i = 0; i < 6; i++) begin
                    @(negedge CLK);
                    LEDS = v[i];
                end
                @(negedge CLK);
                vectors++;
                if ({level, dropped} !== {3'd4, 8'd1}) begin
                    errors++;
                    $display("FAIL b2b fill: got level=%0d dropped=%0d, expected 4 1", level, dropped);
                end
            end
        join
        wait_idle(ok);
        vectors++;
        if (!ok || ({level, dropped} !== {3'd0, 8'd1})) begin
            errors++;
            $display("FAIL b2b drain: got idle=%b level=%0d dropped=%0d, expected 1 0 1", ok, level, dropped);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int s;
        int bad;
        @(negedge CLK);
        LEDS = 32'h1200_0078;
        rx_byte("midrst b0", exp_byte(32'h1200_0078, 0));
        rx_byte("midrst b1", exp_byte(32'h1200_0078, 1));
        wait_fall(ok);
        repeat (6) @(negedge CLK);
        vectors++;
        if (!ok || TXD !== 1'b0) begin
            errors++;
            $display("FAIL midrst data bit: got txd=%b started=%b, expected 0 1", TXD, ok);
        end
        #1 RESET = 1'b0;
        #1;
        vectors++;
        if ({TXD, busy, level, dropped} !== {1'b1, 1'b0, 3'd0, 8'd0}) begin
            errors++;
            $display("FAIL midrst assert: got txd=%b busy=%b level=%0d dropped=%0d, expected 1 0 0 0",
                     TXD, busy, level, dropped);
        end
        LEDS = '0;
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (TXD !== 1'b1 || level !== 3'd0 || busy !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midrst residue: got %0d non-idle cycles, expected 0", bad);
        end
        @(negedge CLK);
        LEDS = 32'hCAFE_0001;
        rx_word("midrst fresh", 32'hCAFE_0001, s);
        wait_idle(ok);
        vectors++;
        if (!ok || level !== 3'd0) begin
            errors++;
            $display("FAIL midrst fresh idle: got idle=%b level=%0d, expected 1 0", ok, level);
        end
    endtask

    task automatic test_saturation();
        @(negedge CLK);
        RESET = 1'b0;
        LEDS  = '0;
        @(negedge CLK);
        RESET = 1'b1;
        for (int i = 1; i <= 330; i++) begin
            @(negedge CLK);
            LEDS = i;
        end
        @(negedge CLK);
        vectors++;
        if (level !== 3'd4) begin
            errors++;
            $display("FAIL sat level: got %0d, expected 4", level);
        end
        vectors++;
        if (dropped !== 8'd255) begin
            errors++;
            $display("FAIL sat dropped: got %0d, expected 255", dropped);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            LEDS = 32'h0001_0000 + i;
        end
        @(negedge CLK);
        vectors++;
        if (dropped !== 8'd255) begin
            errors++;
            $display("FAIL sat hold: got %0d, expected 255", dropped);
        end
        #1 RESET = 1'b0;
        #1;
        vectors++;
        if ({dropped, level, TXD} !== {8'd0, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL sat reset: got dropped=%0d level=%0d txd=%b, expected 0 0 1", dropped, level, TXD);
        end
        LEDS = '0;
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    initial begin
        test_reset();
`ifdef LEDS_REPORT_HEX_EN
        test_hex();
`else
        test_raw_word();
`endif
        test_back_to_back();
        test_reset_mid_frame();
        test_saturation();
        repeat (4) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
